// File: rtl/mem_controller_burst.sv
// mem_controller_burst: paged burst memory controller on a shared multiplexed
// AddrData bus. An address beat whose top nibble matches PAGE starts a read or
// write burst of BURST_LEN beats. The burst runs within one aligned group of
// BURST_LEN words and wraps inside that group. Optional wait states precede the
// first data beat.
module mem_controller_burst #(
    parameter logic [3:0] PAGE        = 4'h1,
    parameter int         DATA_W      = 16,
    parameter int         ADDR_W      = 12,
    parameter int         BURST_LEN   = 4,
    parameter int         WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              resetL,
    inout  wire  [DATA_W-1:0] AddrData,
    input  logic              AddrValid,
    input  logic              rw,
    output logic              Ready
);

    localparam int                CNT_W     = $clog2(BURST_LEN) + 1;
    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] BEAT_MASK = ADDR_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [3:0]        WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RD   = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic              r_rw;
    logic [3:0]        r_wait_cnt;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              r_ready;
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    logic              w_page_hit;
    logic [ADDR_W-1:0] w_beat_addr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_bus_oe;

    // An address beat is ours only when AddrValid is high and the page nibble matches.
    assign w_page_hit  = AddrValid && (AddrData[15:12] == PAGE);

    // Upper address bits stay fixed; the low log2(BURST_LEN) bits count modulo BURST_LEN.
    assign w_beat_addr = (r_base & ~BEAT_MASK) |
                         ((r_base + ADDR_W'(r_beat_cnt)) & BEAT_MASK);

    assign w_rdata     = r_mem[w_beat_addr];

    // The bus is driven only while serving read beats; reset forces IDLE, so it releases at once.
    assign w_bus_oe    = (r_state == S_RD);
    assign AddrData    = w_bus_oe ? w_rdata : {DATA_W{1'bz}};
    assign Ready       = r_ready;

    // Burst sequencer: address decode, wait-state countdown and beat counting with registered Ready.
    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_rw       <= 1'b0;
            r_wait_cnt <= 4'd0;
            r_beat_cnt <= '0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wait_cnt <= 4'd0;
                    r_beat_cnt <= '0;
                    if (w_page_hit) begin
                        r_base <= AddrData[ADDR_W-1:0];
                        r_rw   <= rw;
                        if (WAIT_STATES > 0) begin
                            r_state <= S_WAIT;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= rw ? S_RD : S_WR;
                            r_ready <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_state <= r_rw ? S_RD : S_WR;
                        r_ready <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                        r_ready    <= 1'b0;
                    end
                end
                S_RD, S_WR: begin
                    // The beat counter holds at its terminal value on the last beat.
                    if (r_beat_cnt == BEAT_LAST) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b0;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        r_ready    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Word memory: captures the bus at the closing edge of each write beat; reset leaves it intact.
    always_ff @(posedge clk) begin
        if (r_state == S_WR) begin
            r_mem[w_beat_addr] <= AddrData;
        end
    end

endmodule

// File: tb/tb_mem_controller_burst.sv
// Bench for mem_controller_burst. Bus A carries page-1 and page-2 controllers
// with no wait states. Bus B carries a page-1 controller with two wait states.
// The bench keeps a word-array reference model per controller and works out
// burst addresses arithmetically from the base and the burst length.
module tb_mem_controller_burst;

    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        resetL = 1'b0;

    logic        drv_a_en = 1'b0, drv_b_en = 1'b0;
    logic [15:0] drv_a = 16'h0000, drv_b = 16'h0000;
    logic        av_a = 1'b0, av_b = 1'b0;
    logic        rw_a = 1'b0, rw_b = 1'b0;
    logic        ready_p1, ready_p2, ready_w2;
    wire  [15:0] bus_a;
    wire  [15:0] bus_b;

    assign bus_a = drv_a_en ? drv_a : 16'bz;
    assign bus_b = drv_b_en ? drv_b : 16'bz;

    int total = 0;
    int bad   = 0;

    logic [15:0] model [0:2][0:4095];

    always #5 clk = ~clk;

    mem_controller_burst #(.PAGE(4'h1), .WAIT_STATES(0)) u_p1 (
        .clk(clk), .resetL(resetL), .AddrData(bus_a),
        .AddrValid(av_a), .rw(rw_a), .Ready(ready_p1));

    mem_controller_burst #(.PAGE(4'h2), .WAIT_STATES(0)) u_p2 (
        .clk(clk), .resetL(resetL), .AddrData(bus_a),
        .AddrValid(av_a), .rw(rw_a), .Ready(ready_p2));

    mem_controller_burst #(.PAGE(4'h1), .WAIT_STATES(2)) u_w2 (
        .clk(clk), .resetL(resetL), .AddrData(bus_b),
        .AddrValid(av_b), .rw(rw_b), .Ready(ready_w2));

    // Which model array owns an address on a given bus (-1: nobody).
    function automatic int owner(bit sel, logic [15:0] addr);
        if (sel) return (addr[15:12] == 4'h1) ? 2 : -1;
        if (addr[15:12] == 4'h1) return 0;
        if (addr[15:12] == 4'h2) return 1;
        return -1;
    endfunction

    function automatic int beat_addr(int base, int k);
        return (base / BL) * BL + ((base % BL) + k) % BL;
    endfunction

    function automatic logic [15:0] ready_vec();
        return {13'd0, ready_w2, ready_p2, ready_p1};
    endfunction

    function automatic logic [15:0] oe_vec();
        return {13'd0, u_w2.w_bus_oe, u_p2.w_bus_oe, u_p1.w_bus_oe};
    endfunction

    task automatic drive(bit sel, bit en, logic [15:0] val, bit av, bit r);
        if (sel) begin
            drv_b_en = en; drv_b = val; av_b = av; rw_b = r;
        end else begin
            drv_a_en = en; drv_a = val; av_a = av; rw_a = r;
        end
    endtask

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete burst: address beat, ws wait cycles, BL beats, one idle cycle.
    // av_beat >= 0 re-asserts AddrValid during that read beat (must be ignored).
    task automatic burst(bit sel, logic [15:0] addr, bit r, int ws, int av_beat,
                         logic [63:0] wd, string tag);
        int          own;
        int          base;
        int          a;
        logic [15:0] rexp;
        logic [15:0] bus_v;
        own  = owner(sel, addr);
        base = int'(addr[11:0]);
        rexp = (own >= 0) ? 16'(1 << own) : 16'd0;
        @(negedge clk);
        drive(sel, 1'b1, addr, 1'b1, r);
        #1;
        chk({tag, "_abeat_rdy"}, ready_vec(), 16'd0);
        for (int w = 0; w < ws; w++) begin
            @(negedge clk);
            drive(sel, 1'b0, 16'h0000, 1'b0, r);
            #1;
            chk({tag, "_wait_rdy"}, ready_vec(), 16'd0);
            chk({tag, "_wait_oe"}, oe_vec(), 16'd0);
        end
        for (int k = 0; k < BL; k++) begin
            @(negedge clk);
            if (r) drive(sel, 1'b0, 16'h0000, (k == av_beat), 1'b1);
            else   drive(sel, 1'b1, wd[16*k +: 16], 1'b0, 1'b0);
            #1;
            a = beat_addr(base, k);
            chk({tag, "_beat_rdy"}, ready_vec(), rexp);
            chk({tag, "_beat_oe"}, oe_vec(), r ? rexp : 16'd0);
            if (own >= 0) begin
                if (r) begin
                    bus_v = sel ? bus_b : bus_a;
                    chk({tag, "_rdata"}, bus_v, model[own][a]);
                end else begin
                    model[own][a] = wd[16*k +: 16];
                end
            end
        end
        @(negedge clk);
        drive(sel, 1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        chk({tag, "_end_rdy"}, ready_vec(), 16'd0);
        chk({tag, "_end_oe"}, oe_vec(), 16'd0);
    endtask

    initial begin
        logic        sel;
        logic [15:0] addr;
        logic [15:0] raddr;

        // Reset state.
        @(negedge clk); #1;
        chk("rst_rdy", ready_vec(), 16'd0);
        chk("rst_oe", oe_vec(), 16'd0);
        @(negedge clk);
        resetL = 1'b1;

        // Reset in the middle of a read burst.
        burst(1'b0, 16'h1010, 1'b0, 0, -1, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}, "rst_wr");
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h1010, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        chk("rstmid_b0", bus_a, 16'h00A0);
        @(negedge clk); #1;
        chk("rstmid_b1", bus_a, 16'h00A1);
        #2 resetL = 1'b0;
        #1;
        chk("rstmid_oe", oe_vec(), 16'd0);
        chk("rstmid_rdy", ready_vec(), 16'd0);
        @(negedge clk);
        resetL = 1'b1;
        #1;
        chk("rstrel_oe", oe_vec(), 16'd0);
        burst(1'b0, 16'h1010, 1'b1, 0, -1, 64'd0, "rst_reread");

        // Two instances sharing bus A.
        burst(1'b0, 16'h1020, 1'b0, 0, -1, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, "p1_wr");
        burst(1'b0, 16'h2020, 1'b0, 0, -1, {16'h8888, 16'h7777, 16'h6666, 16'h5555}, "p2_wr");
        burst(1'b0, 16'h1020, 1'b1, 0, -1, 64'd0, "p1_rd");
        burst(1'b0, 16'h2020, 1'b1, 0, -1, 64'd0, "p2_rd");

        // Wrap-around within the aligned group.
        burst(1'b0, 16'h1000, 1'b0, 0, -1, {16'd3, 16'd2, 16'd1, 16'd0}, "wrap_wr");
        burst(1'b0, 16'h1002, 1'b1, 0, -1, 64'd0, "wrap_rd");
        burst(1'b0, 16'h1FFC, 1'b0, 0, -1, {$urandom, $urandom}, "top_wr");
        burst(1'b0, 16'h1FFF, 1'b1, 0, -1, 64'd0, "top_rd");

        // Two wait states on bus B.
        burst(1'b1, 16'h1020, 1'b0, 2, -1, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, "ws_wr");
        burst(1'b1, 16'h1020, 1'b1, 2, -1, 64'd0, "ws_rd");

        // AddrValid during beat 2 while the bus shows 16'h1040 must be ignored.
        burst(1'b0, 16'h1020, 1'b0, 0, -1, {16'h4444, 16'h1040, 16'h2222, 16'h1111}, "ign_wr");
        burst(1'b0, 16'h1020, 1'b1, 0, 2, 64'd0, "ign_rd");
        @(negedge clk); #1;
        chk("ign_idle_rdy", ready_vec(), 16'd0);

        // Page 3 has no owner: nothing answers, nothing drives.
        burst(1'b0, 16'h3020, 1'b1, 0, -1, 64'd0, "p3_rd");

        // Randomized write-then-read within the same aligned group.
        for (int i = 0; i < 12; i++) begin
            sel   = 1'($urandom_range(0, 1));
            addr  = {sel ? 4'h1 : 4'($urandom_range(1, 2)), 12'($urandom)};
            raddr = {addr[15:2], 2'($urandom)};
            burst(sel, addr, 1'b0, sel ? 2 : 0, -1, {$urandom, $urandom}, "rnd_wr");
            burst(sel, raddr, 1'b1, sel ? 2 : 0, -1, 64'd0, "rnd_rd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
